// File: rtl/multi_phase_traffic_controller.sv
// Actuated round-robin traffic controller: NUM_PHASES exclusive phases with min/max
// green, yellow, all-red clearance, latched pedestrian WALK and a night-flash mode.
module multi_phase_traffic_controller #(
    parameter int NUM_PHASES = 2,
    parameter int CLK_DIV    = 50,
    parameter int GREEN_MIN  = 5,
    parameter int GREEN_MAX  = 10,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 1,
    parameter int WALK_T     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PHASES-1:0]         veh_req,
    input  logic [NUM_PHASES-1:0]         ped_req,
    input  logic                          flash_en,
    output logic [NUM_PHASES-1:0]         green,
    output logic [NUM_PHASES-1:0]         yellow,
    output logic [NUM_PHASES-1:0]         red,
    output logic [NUM_PHASES-1:0]         walk,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic                          tick
);
    localparam int PW    = $clog2(NUM_PHASES);
    localparam int DW    = $clog2(CLK_DIV);
    // Timer must be able to reach the longest state duration, whichever it is.
    localparam int T_A   = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
    localparam int T_SAT = (T_A > ALLRED_T) ? T_A : ALLRED_T;
    localparam int TW    = $clog2(T_SAT + 1);

    typedef enum logic [1:0] {S_ALL_RED, S_GREEN, S_YELLOW, S_FLASH} state_t;

    state_t                r_state, w_nstate;
    logic [PW-1:0]         r_phase, w_nphase, w_adv;
    logic [TW-1:0]         r_timer, w_ntimer;
    logic [DW-1:0]         r_div;
    logic                  r_tick;
    logic                  r_first, w_nfirst;
    logic                  r_walk_srv, w_nwalk_srv;
    logic                  r_blink, w_nblink;
    logic [NUM_PHASES-1:0] r_ped_pend, w_clr;
    logic [NUM_PHASES-1:0] r_green, r_yellow, r_red, r_walk;
    logic [NUM_PHASES-1:0] w_onehot, w_g, w_y, w_r, w_w;
    logic                  w_demand_other;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (r_div == DW'(CLK_DIV - 1)) begin
            r_div  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_div  <= r_div + 1'b1;
            r_tick <= 1'b0;
        end
    end

    always_comb begin
        w_demand_other = 1'b0;
        for (int i = 0; i < NUM_PHASES; i++)
            if (PW'(i) != r_phase) w_demand_other = w_demand_other | veh_req[i] | r_ped_pend[i];
    end

    assign w_adv = (r_phase == PW'(NUM_PHASES - 1)) ? '0 : r_phase + 1'b1;

    always_comb begin
        w_nstate    = r_state;
        w_nphase    = r_phase;
        w_ntimer    = r_timer;
        w_nfirst    = r_first;
        w_nwalk_srv = r_walk_srv;
        w_nblink    = r_blink;
        w_clr       = '0;
        if (r_tick) begin
            w_ntimer = (r_timer == TW'(T_SAT - 1)) ? r_timer : r_timer + 1'b1;
            if (flash_en && r_state != S_FLASH) begin
                w_nstate = S_FLASH;
                w_nblink = 1'b0;
            end else begin
                case (r_state)
                    S_ALL_RED:
                        if (r_timer >= TW'(ALLRED_T - 1)) begin
                            w_nstate        = S_GREEN;
                            w_nphase        = r_first ? '0 : w_adv;
                            w_nfirst        = 1'b0;
                            w_nwalk_srv     = r_ped_pend[w_nphase];
                            w_clr[w_nphase] = 1'b1;
                        end
                    // Gap-out at GREEN_MIN also covers max-out; without demand green rests.
                    S_GREEN:
                        if (r_timer >= TW'(GREEN_MIN - 1) && w_demand_other) w_nstate = S_YELLOW;
                    S_YELLOW:
                        if (r_timer >= TW'(YELLOW_T - 1)) w_nstate = S_ALL_RED;
                    default:
                        if (flash_en) begin
                            w_nblink = ~r_blink;
                        end else begin
                            w_nstate = S_ALL_RED;
                            w_nphase = '0;
                            w_nfirst = 1'b1;
                            w_nblink = 1'b0;
                        end
                endcase
            end
            if (w_nstate != r_state) w_ntimer = '0;
        end
    end

    // Lamps are decoded from next-state values so they switch on the same edge as the state.
    always_comb begin
        w_onehot           = '0;
        w_onehot[w_nphase] = 1'b1;
        w_g                = '0;
        w_y                = '0;
        w_r                = '1;
        w_w                = '0;
        case (w_nstate)
            S_GREEN: begin
                w_g = w_onehot;
                w_r = ~w_onehot;
                if (w_nwalk_srv && w_ntimer < TW'(WALK_T)) w_w = w_onehot;
            end
            S_YELLOW: begin
                w_y = w_onehot;
                w_r = ~w_onehot;
            end
            S_FLASH: begin
                w_y = {NUM_PHASES{w_nblink}};
                w_r = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_ALL_RED;
            r_phase    <= '0;
            r_timer    <= '0;
            r_first    <= 1'b1;
            r_walk_srv <= 1'b0;
            r_blink    <= 1'b0;
            r_ped_pend <= '0;
            r_green    <= '0;
            r_yellow   <= '0;
            r_red      <= '1;
            r_walk     <= '0;
        end else begin
            r_state    <= w_nstate;
            r_phase    <= w_nphase;
            r_timer    <= w_ntimer;
            r_first    <= w_nfirst;
            r_walk_srv <= w_nwalk_srv;
            r_blink    <= w_nblink;
            r_ped_pend <= (r_ped_pend | ped_req) & ~w_clr;
            r_green    <= w_g;
            r_yellow   <= w_y;
            r_red      <= w_r;
            r_walk     <= w_w;
        end
    end

    assign green  = r_green;
    assign yellow = r_yellow;
    assign red    = r_red;
    assign walk   = r_walk;
    assign phase  = r_phase;
    assign tick   = r_tick;
endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Directed bench for multi_phase_traffic_controller: 2 phases, 4-cycle tick, default timings.
module tb_multi_phase_traffic_controller;
    localparam int CD = 4;
    localparam int AR = 0, G0 = 1, G1 = 2, Y0 = 3, Y1 = 4, F0 = 5, F1 = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] veh_req, ped_req;
    logic       flash_en;
    logic [1:0] green, yellow, red, walk;
    logic [0:0] phase;
    logic       tick;
    logic [1:0] prev_g;

    int compared   = 0;
    int mismatched = 0;

    // One observed tick period: expected lamp code, walk, phase; then inputs to apply.
    typedef struct packed {
        logic [3:0] code;
        logic [1:0] w;
        logic [1:0] veh;
        logic [1:0] ped;
        logic       fl;
        logic       ph;
    } step_t;

    multi_phase_traffic_controller #(
        .NUM_PHASES(2), .CLK_DIV(CD), .GREEN_MIN(5), .GREEN_MAX(10),
        .YELLOW_T(3), .ALLRED_T(1), .WALK_T(4)
    ) dut (
        .clk(clk), .rst(rst), .veh_req(veh_req), .ped_req(ped_req), .flash_en(flash_en),
        .green(green), .yellow(yellow), .red(red), .walk(walk), .phase(phase), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic step_t st(input int code, input logic [1:0] w, input logic [1:0] veh,
                                 input logic [1:0] ped, input logic fl, input logic ph);
        step_t s;
        s.code = 4'(code);
        s.w    = w;
        s.veh  = veh;
        s.ped  = ped;
        s.fl   = fl;
        s.ph   = ph;
        return s;
    endfunction

    // {green, yellow, red} expected for each lamp code
    function automatic logic [5:0] lamps(input int code);
        case (code)
            AR:      return 6'b00_00_11;
            G0:      return 6'b01_00_10;
            G1:      return 6'b10_00_01;
            Y0:      return 6'b00_01_10;
            Y1:      return 6'b00_10_01;
            F0:      return 6'b00_00_00;
            default: return 6'b00_11_00;
        endcase
    endfunction

    // Advance to the negedge just after the next state-update edge.
    task automatic next_tick();
        bit found = 1'b0;
        for (int n = 0; n < 2 * CD && !found; n++) begin
            @(negedge clk);
            if (tick === 1'b1) found = 1'b1;
        end
        if (!found) begin
            compared++;
            mismatched++;
            $display("FAIL tick_timeout t=%0t: no tick within %0d cycles", $time, 2 * CD);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; veh_req = 2'b00; ped_req = 2'b00; flash_en = 1'b0;
        @(negedge clk);
        compared++;
        if ({green, yellow, red, walk} !== 8'b00_00_11_00) begin
            mismatched++;
            $display("FAIL reset_lamps: g/y/r/w=%b/%b/%b/%b required 00/00/11/00", green, yellow, red, walk);
        end
        compared++;
        if (phase !== 1'b0 || tick !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_phase_tick: phase=%b tick=%b required 0/0", phase, tick);
        end
        rst = 1'b0;
        for (int c = 1; c <= CD; c++) begin
            @(negedge clk);
            compared++;
            if (tick !== (c == CD)) begin
                mismatched++;
                $display("FAIL reset_tick_cycle %0d: tick=%b required %b", c, tick, c == CD);
            end
        end
        @(negedge clk);
        compared++;
        if ({green, red, phase} !== 5'b01_10_0) begin
            mismatched++;
            $display("FAIL reset_first_green: green=%b red=%b phase=%b required 01/10/0", green, red, phase);
        end
        for (int k = 0; k < 12; k++) begin
            next_tick();
            compared++;
            if ({green, yellow, red} !== 6'b01_00_10) begin
                mismatched++;
                $display("FAIL idle_rest tick %0d: g/y/r=%b/%b/%b required 01/00/10", k, green, yellow, red);
            end
        end
    endtask

    task automatic test_gap_out();
        step_t q[$];
        logic [5:0] e;
        rst = 1'b1; veh_req = 2'b10;
        @(negedge clk);
        rst = 1'b0;
        repeat (5)  q.push_back(st(G0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
        repeat (3)  q.push_back(st(Y0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
        q.push_back(st(AR, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
        repeat (13) q.push_back(st(G1, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1));
        foreach (q[k]) begin
            next_tick();
            e = lamps(int'(q[k].code));
            compared++;
            if ({green, yellow, red} !== e) begin
                mismatched++;
                $display("FAIL gap_out step %0d: g/y/r=%b/%b/%b required %b/%b/%b", k, green, yellow, red, e[5:4], e[3:2], e[1:0]);
            end
            compared++;
            if (walk !== q[k].w || phase !== q[k].ph) begin
                mismatched++;
                $display("FAIL gap_out_wp step %0d: walk=%b phase=%b required %b/%b", k, walk, phase, q[k].w, q[k].ph);
            end
            veh_req = q[k].veh; flash_en = q[k].fl;
        end
    endtask

    task automatic test_max_out();
        step_t q[$];
        logic [5:0] e;
        veh_req = 2'b11;
        repeat (3) q.push_back(st(Y1, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1));
        q.push_back(st(AR, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1));
        repeat (5) q.push_back(st(G0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
        repeat (3) q.push_back(st(Y0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
        q.push_back(st(AR, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
        repeat (5) q.push_back(st(G1, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1));
        repeat (3) q.push_back(st(Y1, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1));
        q.push_back(st(AR, 2'b00, 2'b11, 2'b00, 1'b0, 1'b1));
        // Phase 1 demand drops for green ticks 1-6, returns after tick 7.
        repeat (6) q.push_back(st(G0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0));
        q.push_back(st(G0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
        repeat (3) q.push_back(st(Y0, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
        q.push_back(st(AR, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
        repeat (8) q.push_back(st(G1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
        foreach (q[k]) begin
            next_tick();
            e = lamps(int'(q[k].code));
            compared++;
            if ({green, yellow, red} !== e) begin
                mismatched++;
                $display("FAIL max_out step %0d: g/y/r=%b/%b/%b required %b/%b/%b", k, green, yellow, red, e[5:4], e[3:2], e[1:0]);
            end
            compared++;
            if (walk !== q[k].w || phase !== q[k].ph) begin
                mismatched++;
                $display("FAIL max_out_wp step %0d: walk=%b phase=%b required %b/%b", k, walk, phase, q[k].w, q[k].ph);
            end
            veh_req = q[k].veh; flash_en = q[k].fl;
        end
    endtask

    task automatic test_pedestrian();
        step_t q[$];
        logic [5:0] e;
        veh_req = 2'b01;
        repeat (3) q.push_back(st(Y1, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1));
        q.push_back(st(AR, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1));
        q.push_back(st(G0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0));
        repeat (4) q.push_back(st(G0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        repeat (3) q.push_back(st(Y0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        q.push_back(st(AR, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        q.push_back(st(G1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1));
        q.push_back(st(G1, 2'b10, 2'b00, 2'b10, 1'b0, 1'b1));
        repeat (2) q.push_back(st(G1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1));
        repeat (3) q.push_back(st(G1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
        q.push_back(st(G1, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1));
        repeat (3) q.push_back(st(Y1, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1));
        q.push_back(st(AR, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1));
        repeat (5) q.push_back(st(G0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        repeat (3) q.push_back(st(Y0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        q.push_back(st(AR, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        repeat (4) q.push_back(st(G1, 2'b10, 2'b00, 2'b00, 1'b0, 1'b1));
        repeat (2) q.push_back(st(G1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
        foreach (q[k]) begin
            next_tick();
            e = lamps(int'(q[k].code));
            compared++;
            if ({green, yellow, red} !== e) begin
                mismatched++;
                $display("FAIL pedestrian step %0d: g/y/r=%b/%b/%b required %b/%b/%b", k, green, yellow, red, e[5:4], e[3:2], e[1:0]);
            end
            compared++;
            if (walk !== q[k].w || phase !== q[k].ph) begin
                mismatched++;
                $display("FAIL pedestrian_wp step %0d: walk=%b phase=%b required %b/%b", k, walk, phase, q[k].w, q[k].ph);
            end
            veh_req = q[k].veh; flash_en = q[k].fl;
            if (q[k].ped != 2'b00) begin
                ped_req = q[k].ped;
                @(negedge clk);
                ped_req = 2'b00;
            end
        end
    endtask

    task automatic test_flash();
        step_t q[$];
        logic [5:0] e;
        flash_en = 1'b1; ped_req = 2'b01;
        @(negedge clk);
        ped_req = 2'b00;
        q.push_back(st(F0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
        q.push_back(st(F1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
        q.push_back(st(F0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
        q.push_back(st(F1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        q.push_back(st(AR, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        repeat (4)  q.push_back(st(G0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0));
        repeat (11) q.push_back(st(G0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0));
        foreach (q[k]) begin
            next_tick();
            e = lamps(int'(q[k].code));
            compared++;
            if ({green, yellow, red} !== e) begin
                mismatched++;
                $display("FAIL flash step %0d: g/y/r=%b/%b/%b required %b/%b/%b", k, green, yellow, red, e[5:4], e[3:2], e[1:0]);
            end
            compared++;
            if (walk !== q[k].w) begin
                mismatched++;
                $display("FAIL flash_walk step %0d: walk=%b required %b", k, walk, q[k].w);
            end
            if (q[k].code < 4'(F0)) begin
                compared++;
                if (phase !== q[k].ph) begin
                    mismatched++;
                    $display("FAIL flash_phase step %0d: phase=%b required %b", k, phase, q[k].ph);
                end
            end
            veh_req = q[k].veh; flash_en = q[k].fl;
        end
    endtask

    task automatic test_async_reset();
        step_t q[$];
        logic [5:0] e;
        veh_req = 2'b10;
        repeat (3) q.push_back(st(Y0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
        q.push_back(st(AR, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
        repeat (5) q.push_back(st(G1, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1));
        q.push_back(st(Y1, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1));
        foreach (q[k]) begin
            next_tick();
            e = lamps(int'(q[k].code));
            compared++;
            if ({green, yellow, red} !== e || phase !== q[k].ph) begin
                mismatched++;
                $display("FAIL async_pre step %0d: g/y/r=%b/%b/%b phase=%b required %b/%b/%b/%b", k, green, yellow, red, phase, e[5:4], e[3:2], e[1:0], q[k].ph);
            end
            veh_req = q[k].veh; flash_en = q[k].fl;
        end
        // Mid-period, clock low: reset must act with no clock edge.
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({green, yellow, red, walk, phase, tick} !== 10'b00_00_11_00_0_0) begin
            mismatched++;
            $display("FAIL async_reset: g/y/r/w=%b/%b/%b/%b phase=%b tick=%b required 00/00/11/00 0 0", green, yellow, red, walk, phase, tick);
        end
        veh_req = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= CD; c++) begin
            @(negedge clk);
            compared++;
            if (tick !== (c == CD)) begin
                mismatched++;
                $display("FAIL async_tick_cycle %0d: tick=%b required %b", c, tick, c == CD);
            end
        end
        @(negedge clk);
        compared++;
        if ({green, red, phase} !== 5'b01_10_0) begin
            mismatched++;
            $display("FAIL async_restart_green: green=%b red=%b phase=%b required 01/10/0", green, red, phase);
        end
    endtask

    // Safety properties checked on every cycle out of reset.
    initial begin
        prev_g = 2'b00;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                compared++;
                if ((green & yellow) !== 2'b00 ||
                    (red !== 2'b00 && (((green | yellow) & red) !== 2'b00 || $countones(~red) > 1)) ||
                    (prev_g !== 2'b00 && green !== 2'b00 && green !== prev_g)) begin
                    mismatched++;
                    $display("FAIL invariant t=%0t: g/y/r=%b/%b/%b prev_green=%b", $time, green, yellow, red, prev_g);
                end
                prev_g = green;
            end else begin
                prev_g = 2'b00;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; veh_req = 2'b00; ped_req = 2'b00; flash_en = 1'b0;
        test_reset();
        test_gap_out();
        test_max_out();
        test_pedestrian();
        test_flash();
        test_async_reset();
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
